// File: rtl/dmac_pkg.sv
// ---------------------------------------------------------------------------
// dmac_pkg
//   Shared types and constants for the DMAC secondary-port memory responder.
//   - state_e        : responder FSM states (IDLE, WAIT, DONE)
//   - WR / RD        : encoding of the wr_rd request bit
//   - DEF_ADR_SIZE   : default address width
//   - DEF_DATA_SIZE  : default data word width
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  localparam int DEF_ADR_SIZE  = 16;
  localparam int DEF_DATA_SIZE = 16;

endpackage

`default_nettype wire

// File: rtl/ext_mem_array.sv
// ---------------------------------------------------------------------------
// ext_mem_array
//   Synchronous single-port DEPTH x DATA_SIZE RAM with a registered read port.
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous active-high reset (read register only)
//     we_i     in   write enable
//     re_i     in   read enable; loads rdata_o from mem[addr_i]
//     clr_i    in   clears rdata_o (used for out-of-range reads)
//     addr_i   in   word index
//     wdata_i  in   write data
//     rdata_o  out  registered read data; holds its value when idle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ext_mem_array #(
  parameter int DEPTH     = 1024,
  parameter int DATA_SIZE = 16,
  parameter int AW        = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic                 clr_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] rdata_q;

  // Storage is deliberately left out of reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ext_mem_responder.sv
// ---------------------------------------------------------------------------
// ext_mem_responder
//   Responder for the DMAC secondary-port memory interface. Accepts single
//   word read/write requests, inserts a programmable number of wait states,
//   then services the access from an internal word array.
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-high reset
//     en         in   request valid, held until ack or abort
//     wr_rd      in   1 = write, 0 = read
//     addr       in   word address
//     data_in    in   write data
//     ws_load    in   strobe: load ws_val into the wait-state register
//     ws_val     in   new wait-state count
//     data_out   out  registered read data (0 after an out-of-range read)
//     stall_ext  out  high while a request is pending and not completing
//     ack        out  one-cycle completion pulse
//     err        out  one-cycle pulse with ack for out-of-range addresses
//     xfer_cnt   out  completed non-error access count (wraps)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ext_mem_responder
  import dmac_pkg::*;
#(
  parameter int          ADR_SIZE   = DEF_ADR_SIZE,
  parameter int          DATA_SIZE  = DEF_DATA_SIZE,
  parameter int          DEPTH      = 1024,
  parameter logic [3:0]  WS_DEFAULT = 4'd2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr_rd,
  input  logic [ADR_SIZE-1:0]  addr,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 ws_load,
  input  logic [3:0]           ws_val,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 stall_ext,
  output logic                 ack,
  output logic                 err,
  output logic [15:0]          xfer_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADR_SIZE:0] DEPTH_W = (ADR_SIZE+1)'(DEPTH);

  state_e                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [3:0]            ws_q;
  logic                  wr_q;
  logic [ADR_SIZE-1:0]   addr_q;
  logic [DATA_SIZE-1:0]  wdata_q;
  logic                  ack_q;
  logic                  err_q;
  logic [15:0]           xfer_q;

  logic                  accept;
  logic                  do_access;
  logic                  in_range;
  logic                  ram_we, ram_re, ram_clr;

  // Next-state logic. Acceptance is shared by IDLE and DONE so that a request
  // presented during DONE starts immediately (back-to-back operation).
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) accept = 1'b1;
      end
      WAIT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (wcnt_q == 4'd1) begin
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      DONE: begin
        if (en) accept = 1'b1;
        else    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // ws_q here is the pre-load value, so a coincident ws_load waits for the
    // following request.
    if (accept) begin
      wcnt_d  = ws_q;
      state_d = (ws_q == 4'd0) ? DONE : WAIT;
    end
  end

  assign do_access = (state_q == DONE);
  assign in_range  = ({1'b0, addr_q} < DEPTH_W);
  assign ram_we    = do_access & (wr_q == WR) & in_range;
  assign ram_re    = do_access & (wr_q == RD) & in_range;
  assign ram_clr   = do_access & (wr_q == RD) & ~in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      ws_q    <= WS_DEFAULT;
      wr_q    <= RD;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      xfer_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (ws_load) ws_q <= ws_val;
      if (accept) begin
        wr_q    <= wr_rd;
        addr_q  <= addr;
        wdata_q <= data_in;
      end
      ack_q <= do_access;
      err_q <= do_access & ~in_range;
      if (do_access && in_range) xfer_q <= xfer_q + 16'd1;
    end
  end

  ext_mem_array #(
    .DEPTH     (DEPTH),
    .DATA_SIZE (DATA_SIZE),
    .AW        (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .clr_i   (ram_clr),
    .addr_i  (addr_q[AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (data_out)
  );

  // The access completes in DONE, so the requester is released that cycle.
  assign stall_ext = en & ~rst & (state_q != DONE);
  assign ack       = ack_q;
  assign err       = err_q;
  assign xfer_cnt  = xfer_q;

endmodule

`default_nettype wire

// File: tb/tb_ext_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_ext_mem_responder
//   Directed self-checking bench for ext_mem_responder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ext_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wr_rd;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        ws_load;
  logic [3:0]  ws_val;
  logic [15:0] data_out;
  logic        stall_ext;
  logic        ack;
  logic        err;
  logic [15:0] xfer_cnt;

  int checks   = 0;
  int failures = 0;

  ext_mem_responder #(
    .ADR_SIZE   (16),
    .DATA_SIZE  (16),
    .DEPTH      (1024),
    .WS_DEFAULT (4'd2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wr_rd     (wr_rd),
    .addr      (addr),
    .data_in   (data_in),
    .ws_load   (ws_load),
    .ws_val    (ws_val),
    .data_out  (data_out),
    .stall_ext (stall_ext),
    .ack       (ack),
    .err       (err),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated access: request, ws wait cycles, DONE, then ack.
  // Request fields are scrambled after acceptance to show they are latched.
  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input int ws, input logic exp_err, input logic [15:0] exp_rd);
    en = 1'b1; wr_rd = wr; addr = a; data_in = d;
    #1 chk("stall_req", stall_ext, 1);
    step();
    wr_rd = ~wr; addr = a ^ 16'h0001; data_in = ~d;
    for (int i = 0; i < ws; i++) begin
      #1;
      chk("stall_wait", stall_ext, 1);
      chk("ack_wait", ack, 0);
      step();
    end
    #1 chk("stall_done", stall_ext, 0);
    en = 1'b0;
    step();
    chk("ack", ack, 1);
    chk("err", err, exp_err);
    if (wr == 1'b0) chk("rdata", data_out, exp_rd);
    step();
    chk("ack_drop", ack, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_rd = 1'b0; addr = '0; data_in = '0;
    ws_load = 1'b0; ws_val = 4'd0;
    step(); step();
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_dout", data_out, 0);
    en = 1'b1;
    #1 chk("rst_stall", stall_ext, 0);
    en = 1'b0;
    rst = 1'b0;
    step();

    // Default two wait states: write then read back.
    access(1'b1, 16'h0010, 16'hA5A5, 2, 1'b0, 16'h0000);
    chk("xfer_wr", xfer_cnt, 1);
    access(1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'hA5A5);
    chk("xfer_rd", xfer_cnt, 2);

    // Zero wait states: preload then back-to-back reads.
    ws_load = 1'b1; ws_val = 4'd0;
    step();
    ws_load = 1'b0;
    access(1'b1, 16'h0000, 16'h1111, 0, 1'b0, 16'h0000);
    access(1'b1, 16'h0001, 16'h2222, 0, 1'b0, 16'h0000);
    access(1'b1, 16'h0002, 16'h3333, 0, 1'b0, 16'h0000);
    access(1'b1, 16'h0003, 16'h4444, 0, 1'b0, 16'h0000);
    chk("xfer_preload", xfer_cnt, 6);
    en = 1'b1; wr_rd = 1'b0; addr = 16'h0000;
    #1 chk("b2b_stall_idle", stall_ext, 1);
    step();
    addr = 16'h0001;
    #1 chk("b2b_stall_done", stall_ext, 0);
    step();
    chk("b2b_ack0", ack, 1);
    chk("b2b_d0", data_out, 16'h1111);
    addr = 16'h0002;
    #1 chk("b2b_stall_done", stall_ext, 0);
    step();
    chk("b2b_ack1", ack, 1);
    chk("b2b_d1", data_out, 16'h2222);
    addr = 16'h0003;
    step();
    chk("b2b_ack2", ack, 1);
    chk("b2b_d2", data_out, 16'h3333);
    en = 1'b0;
    step();
    chk("b2b_ack3", ack, 1);
    chk("b2b_d3", data_out, 16'h4444);
    step();
    chk("b2b_ack_drop", ack, 0);
    chk("xfer_b2b", xfer_cnt, 10);

    // ws_load coincident with acceptance: old value (0) applies.
    ws_load = 1'b1; ws_val = 4'd3;
    en = 1'b1; wr_rd = 1'b1; addr = 16'h0020; data_in = 16'h1234;
    step();
    ws_load = 1'b0;
    #1 chk("oldws_stall", stall_ext, 0);
    en = 1'b0;
    step();
    chk("oldws_ack", ack, 1);
    chk("xfer_oldws", xfer_cnt, 11);
    step();

    // Abort a three-wait-state write by dropping en.
    en = 1'b1; wr_rd = 1'b1; addr = 16'h0020; data_in = 16'hBEEF;
    step(); step();
    #1 chk("abort_stall_wait", stall_ext, 1);
    en = 1'b0;
    #1 chk("abort_stall_drop", stall_ext, 0);
    step();
    chk("abort_ack0", ack, 0);
    step();
    chk("abort_ack1", ack, 0);
    chk("xfer_abort", xfer_cnt, 11);
    access(1'b0, 16'h0020, 16'h0000, 3, 1'b0, 16'h1234);
    chk("xfer_after_abort", xfer_cnt, 12);

    // Out-of-range accesses.
    access(1'b0, 16'h0400, 16'h0000, 3, 1'b1, 16'h0000);
    chk("xfer_oor_rd", xfer_cnt, 12);
    access(1'b1, 16'h0400, 16'h9999, 3, 1'b1, 16'h0000);
    chk("xfer_oor_wr", xfer_cnt, 12);
    access(1'b0, 16'h0000, 16'h0000, 3, 1'b0, 16'h1111);
    chk("xfer_alias_rd", xfer_cnt, 13);

    // Reset in the middle of a wait.
    en = 1'b1; wr_rd = 1'b1; addr = 16'h0020; data_in = 16'h5555;
    step(); step();
    rst = 1'b1;
    #1 chk("midrst_stall", stall_ext, 0);
    step();
    rst = 1'b0; en = 1'b0;
    #1;
    chk("midrst_stall_after", stall_ext, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_err", err, 0);
    chk("midrst_xfer", xfer_cnt, 0);
    chk("midrst_dout", data_out, 0);
    step();
    access(1'b0, 16'h0020, 16'h0000, 2, 1'b0, 16'h1234);
    chk("xfer_post_rst", xfer_cnt, 1);

    // Counter wrap using continuous back-to-back reads.
    ws_load = 1'b1; ws_val = 4'd0;
    step();
    ws_load = 1'b0;
    en = 1'b1; wr_rd = 1'b0; addr = 16'h0000;
    step();
    repeat (65534) step();
    chk("xfer_ffff", xfer_cnt, 16'hFFFF);
    en = 1'b0;
    step();
    chk("wrap_ack", ack, 1);
    chk("xfer_wrap", xfer_cnt, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
